// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared constants and types for the iterative multiply/divide
//             unit: op encodings, FSM state enum, iteration count and the
//             divide-by-zero LO value.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // Operand width and number of shift-add / restoring steps
    localparam int ITER_CNT = 32;

    // LO result for any divide by zero (div and divu)
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Op encodings as presented by the decoder
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : Decoder-side bus of the multiply/divide unit.
//  Signals  : start, op[1:0], operand_a, operand_b  - operation launch
//             hi_we, lo_we, wdata                   - mthi/mtlo writes
//             busy, done, hi, lo                    - status and HI/LO
//  Modports : master (decoder/control side), slave (muldiv_unit)
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_CNT
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_div_step
//  Purpose  : One combinational restoring-division iteration. The dividend
//             is held in the quotient register and shifted out MSB first
//             while quotient bits are shifted in at the LSB.
//  Ports    : rem_i  - current partial remainder
//             quo_i  - current quotient / remaining dividend bits
//             div_i  - divisor
//             rem_o  - next partial remainder
//             quo_o  - next quotient / remaining dividend bits
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        // One extra bit so the shifted remainder never overflows
        w_shifted = {rem_i, quo_i[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, div_i};
        if (w_shifted >= {1'b0, div_i}) begin
            rem_o = w_diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = w_shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative MIPS mult/multu/div/divu unit with HI/LO registers
//             and mthi/mtlo write access. Signed operations run on operand
//             magnitudes; the result signs are applied in the FIX state.
//  Ports    : clock  - system clock, rising edge
//             reset  - asynchronous active-high reset
//             bus    - muldiv_if.slave (start/op/operands, hi_we/lo_we/wdata,
//                      busy/done/hi/lo)
//  Build    : MULDIV_FAST_MULT_EN - when defined, mult/multu use a single
//             cycle combinational multiplier and skip the MUL state.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER_CNT
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_q, acc_d;        // MUL: product; DIV: {remainder, quotient}
    logic               neg_res_q, neg_res_d; // sign of product / quotient
    logic               neg_rem_q, neg_rem_d; // sign of remainder (dividend sign)
    logic               is_div_q, is_div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               w_is_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0]   w_rem_n;
    logic [WIDTH-1:0]   w_quo_n;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_prod;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    assign w_is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_a_neg     = w_is_signed & bus.operand_a[WIDTH-1];
    assign w_b_neg     = w_is_signed & bus.operand_b[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign w_a_mag     = w_a_neg ? -bus.operand_a : bus.operand_a;
    assign w_b_mag     = w_b_neg ? -bus.operand_b : bus.operand_b;

`ifdef MULDIV_FAST_MULT_EN
    assign w_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

    // ------------------------------------------------------------------
    // Shift-add multiply step: add the multiplicand to the upper half when
    // the multiplier LSB (acc bit 0) is set, then shift right by one with
    // the carry entering at the top.
    // ------------------------------------------------------------------
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign w_mul_acc = acc_q[0] ? {w_mul_sum, acc_q[WIDTH-1:1]}
                                : {1'b0, acc_q[2*WIDTH-1:1]};

    assign w_rem = acc_q[2*WIDTH-1:WIDTH];
    assign w_quo = acc_q[WIDTH-1:0];

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (w_rem),
        .quo_i (w_quo),
        .div_i (mcand_q),
        .rem_o (w_rem_n),
        .quo_o (w_quo_n)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // start takes priority; a coincident mthi/mtlo is dropped
                    mcand_d   = w_is_div ? w_b_mag : w_a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                    neg_res_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    is_div_d  = w_is_div;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                    if (w_is_div) begin
                        state_d = DIV;
                    end else begin
                        acc_d   = w_prod;
                        state_d = FIX;
                    end
`else
                    state_d = w_is_div ? DIV : MUL;
`endif
                end else begin
                    if (bus.hi_we) begin
                        hi_d = bus.wdata;
                    end
                    if (bus.lo_we) begin
                        lo_d = bus.wdata;
                    end
                end
            end

            MUL: begin
                acc_d = w_mul_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end

            DIV: begin
                acc_d = {w_rem_n, w_quo_n};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_div_q) begin
                    // With a zero divisor the remainder path ends up holding
                    // |dividend|, so re-signing it yields the original
                    // operand_a in HI without extra storage.
                    if (mcand_q == '0) begin
                        lo_d = WIDTH'(DIV0_LO);
                    end else begin
                        lo_d = neg_res_q ? -w_quo : w_quo;
                    end
                    hi_d = neg_rem_q ? -w_rem : w_rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit. A driver issues directed
//             and random operations and pushes the expected HI/LO/latency
//             into a queue; a monitor pops on every done pulse and compares,
//             and also checks busy and HI/LO stability while an op runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          s;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic prev_done;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        e.hi = '0;
        e.lo = '0;
        e.s  = 0;
        e.lat = 34;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
`ifdef MULDIV_FAST_MULT_EN
                e.lat = 2;
`endif
            end
            OP_MULTU: begin
                u = {32'b0, a} * {32'b0, b};
                e.hi = u[63:32];
                e.lo = u[31:0];
`ifdef MULDIV_FAST_MULT_EN
                e.lat = 2;
`endif
            end
            OP_DIV: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Wait (bounded) until no operation is pending; driver acts at negedge+1
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((bus.busy || q.size() != 0) && n < 200);
        if (bus.busy || q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles", bus.busy, q.size(), n);
            q.delete();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic with_we);
        exp_t e;
        wait_idle();
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.hi_we     = with_we;
        bus.lo_we     = with_we;
        bus.wdata     = 32'hA5A5_5A5A;
        e = model(op, a, b);
        @(posedge clk);
        #1;
        e.s = cyc;
        q.push_back(e);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    task automatic mtx(input logic hw, input logic lw, input logic [31:0] d);
        wait_idle();
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = d;
        @(posedge clk);
        #1;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        #1;
        chk("mtx_hi", bus.hi, m_hi);
        chk("mtx_lo", bus.lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    chk("done_single_pulse", {63'b0, prev_done}, 64'd0);
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: hi=%h lo=%h with nothing pending", bus.hi, bus.lo);
                    end else begin
                        e = q.pop_front();
                        chk("result_hi", bus.hi, e.hi);
                        chk("result_lo", bus.lo, e.lo);
                        chk("latency", 64'(cyc - e.s + 1), 64'(e.lat));
                        chk("busy_at_done", {63'b0, bus.busy}, 64'd0);
                        m_hi = e.hi;
                        m_lo = e.lo;
                    end
                end else if (q.size() != 0) begin
                    chk("busy_inflight", {63'b0, bus.busy}, 64'd1);
                    chk("hold_hi", bus.hi, m_hi);
                    chk("hold_lo", bus.lo, m_lo);
                end
                prev_done = bus.done;
            end
        end
    end

    // Driver
    initial begin
        n_cmp = 0;
        n_err = 0;
        m_hi  = '0;
        m_lo  = '0;
        reset = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_done", {63'b0, bus.done}, 64'd0);
        chk("rst_hi", bus.hi, 64'd0);
        chk("rst_lo", bus.lo, 64'd0);
        #1 reset = 1'b0;

        // Directed cases
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(OP_DIVU,  32'd100, 32'd7, 1'b0);
        issue(OP_DIVU,  32'd100, 32'd0, 1'b0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);
        mtx(1'b1, 1'b0, 32'h0000_1234);
        mtx(1'b1, 1'b1, 32'hCAFE_F00D);
        issue(OP_MULTU, 32'd5, 32'd9, 1'b1);   // coincident write must be dropped

        // Second start and writes during a running mult are ignored
        issue(OP_MULT, 32'h0001_0003, 32'hFFFF_0007, 1'b0);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            bus.start     = 1'b1;
            bus.op        = OP_DIVU;
            bus.operand_a = 32'd1000;
            bus.operand_b = 32'd3;
            bus.lo_we     = 1'b1;
            bus.hi_we     = 1'b1;
            bus.wdata     = 32'hDEAD_BEEF;
            @(negedge clk);
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
            bus.hi_we = 1'b0;
        end

        // Reset 10 cycles into a divide: abort, clear, no done
        issue(OP_DIV, 32'd12345, 32'd17, 1'b0);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        q.delete();
        #1;
        chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
        chk("midrst_hi", bus.hi, 64'd0);
        chk("midrst_lo", bus.lo, 64'd0);
        chk("midrst_done", {63'b0, bus.done}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("no_done_after_rst", {63'b0, bus.done}, 64'd0);
        end
        issue(OP_MULTU, 32'd2, 32'd3, 1'b0);

        // Random operations and register writes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                mtx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                issue(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 7) == 0));
            end
        end

        wait_idle();
        chk("all_ops_completed", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
